// File: rtl/dac_spi_streamer.sv
// rtl/dac_spi_streamer.sv - samples the mixer word at the audio rate and ships it as a 16-bit SPI frame to a 12-bit DAC
module dac_spi_streamer #(
    parameter int         CLK_DIV    = 1,
    parameter int         SAMPLE_DIV = 50,
    parameter logic [3:0] PD_BITS    = 4'b0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        clr_ovr,
    input  logic [15:0] sig,
    output logic        dac_sclk,
    output logic        dac_sync_n,
    output logic        dac_din,
    output logic        busy,
    output logic        frame_done,
    output logic        overrun
);

    localparam int TW = $clog2(SAMPLE_DIV);

    typedef enum logic [1:0] {IDLE, SHIFT, STOP} state_t;

    state_t        r_state, w_state_nxt;
    logic [TW-1:0] r_tick_cnt;
    logic          w_tick;
    logic [7:0]    r_half_cnt, w_half_cnt_nxt;
    logic          w_half_last;
    logic [3:0]    r_bit_cnt, w_bit_cnt_nxt;
    logic [15:0]   r_shift, w_shift_nxt;
    logic          r_sclk, w_sclk_nxt;
    logic          r_sync_n, w_sync_n_nxt;
    logic          r_din, w_din_nxt;
    logic          r_busy, w_busy_nxt;
    logic          r_done, w_done_nxt;
    logic          r_ovr, w_ovr_nxt;
    logic          w_unused_lsbs;

    // The DAC only takes 12 bits; the low nibble is truncated, not rounded.
    assign w_unused_lsbs = &{1'b0, sig[3:0]};

    assign w_tick      = enable && (r_tick_cnt == TW'(SAMPLE_DIV - 1));
    assign w_half_last = (r_half_cnt == 8'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_cnt <= '0;
        end else if (!enable || w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_half_cnt <= 8'd0;
            r_bit_cnt  <= 4'd0;
            r_shift    <= 16'd0;
            r_sclk     <= 1'b1;
            r_sync_n   <= 1'b1;
            r_din      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_ovr      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_half_cnt <= w_half_cnt_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_shift    <= w_shift_nxt;
            r_sclk     <= w_sclk_nxt;
            r_sync_n   <= w_sync_n_nxt;
            r_din      <= w_din_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_ovr      <= w_ovr_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_half_cnt_nxt = r_half_cnt;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_shift_nxt    = r_shift;
        w_sclk_nxt     = r_sclk;
        w_sync_n_nxt   = r_sync_n;
        w_din_nxt      = r_din;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;

        // A colliding tick beats a simultaneous clear.
        if (w_tick && (r_state != IDLE)) begin
            w_ovr_nxt = 1'b1;
        end else if (clr_ovr) begin
            w_ovr_nxt = 1'b0;
        end else begin
            w_ovr_nxt = r_ovr;
        end

        case (r_state)
            IDLE: begin
                if (w_tick) begin
                    w_shift_nxt    = {PD_BITS, sig[15:4]};
                    w_din_nxt      = PD_BITS[3];
                    w_sync_n_nxt   = 1'b0;
                    w_sclk_nxt     = 1'b1;
                    w_busy_nxt     = 1'b1;
                    w_bit_cnt_nxt  = 4'd0;
                    w_half_cnt_nxt = 8'd0;
                    w_state_nxt    = SHIFT;
                end
            end
            SHIFT: begin
                if (w_half_last) begin
                    w_half_cnt_nxt = 8'd0;
                    w_sclk_nxt     = ~r_sclk;
                    // Data only moves on the rising edge so it straddles each falling edge.
                    if (!r_sclk) begin
                        if (r_bit_cnt == 4'd15) begin
                            w_state_nxt = STOP;
                        end else begin
                            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                            w_shift_nxt   = {r_shift[14:0], 1'b0};
                            w_din_nxt     = r_shift[14];
                        end
                    end
                end else begin
                    w_half_cnt_nxt = r_half_cnt + 8'd1;
                end
            end
            STOP: begin
                // Single-clock trailer keeps a frame at 32*CLK_DIV+1 clocks.
                w_sync_n_nxt = 1'b1;
                w_busy_nxt   = 1'b0;
                w_done_nxt   = 1'b1;
                w_din_nxt    = 1'b0;
                w_state_nxt  = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign dac_sclk   = r_sclk;
    assign dac_sync_n = r_sync_n;
    assign dac_din    = r_din;
    assign busy       = r_busy;
    assign frame_done = r_done;
    assign overrun    = r_ovr;

endmodule

// File: tb/tb_dac_spi_streamer.sv
// tb/tb_dac_spi_streamer.sv - randomized bench comparing captured SPI frames and flags against a frame-level model
module tb_dac_spi_streamer;

    localparam int MAXN = 1200;

    logic        clk = 1'b0;
    logic        rst_n, clr_ovr;
    logic [15:0] sig;
    logic        en0, en1, en2, en_cur;
    logic        sclk0, sync0, din0, busy0, done0, ovr0;
    logic        sclk1, sync1, din1, busy1, done1, ovr1;
    logic        sclk2, sync2, din2, busy2, done2, ovr2;
    logic        o_sclk, o_sync, o_din, o_busy, o_done, o_ovr;
    int          sel;
    int          n_tests, n_fail;

    logic [15:0] sig_log [MAXN];
    logic        en_log  [MAXN];
    logic        clr_log [MAXN];
    logic        rst_log [MAXN];
    logic        rst_pulse [MAXN];
    logic        ovr_obs [MAXN];
    int          ob_start[$];
    int          ob_len[$];
    int          ob_nbits[$];
    logic [15:0] ob_data[$];

    always #5 clk = ~clk;

    dac_spi_streamer #(.CLK_DIV(1), .SAMPLE_DIV(50), .PD_BITS(4'b0000)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .enable(en0), .clr_ovr(clr_ovr), .sig(sig),
        .dac_sclk(sclk0), .dac_sync_n(sync0), .dac_din(din0),
        .busy(busy0), .frame_done(done0), .overrun(ovr0));

    dac_spi_streamer #(.CLK_DIV(1), .SAMPLE_DIV(20), .PD_BITS(4'b0000)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .enable(en1), .clr_ovr(clr_ovr), .sig(sig),
        .dac_sclk(sclk1), .dac_sync_n(sync1), .dac_din(din1),
        .busy(busy1), .frame_done(done1), .overrun(ovr1));

    dac_spi_streamer #(.CLK_DIV(3), .SAMPLE_DIV(100), .PD_BITS(4'b0000)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .enable(en2), .clr_ovr(clr_ovr), .sig(sig),
        .dac_sclk(sclk2), .dac_sync_n(sync2), .dac_din(din2),
        .busy(busy2), .frame_done(done2), .overrun(ovr2));

    always_comb begin
        {o_sclk, o_sync, o_din, o_busy, o_done, o_ovr} = {sclk0, sync0, din0, busy0, done0, ovr0};
        if (sel == 1) {o_sclk, o_sync, o_din, o_busy, o_done, o_ovr} = {sclk1, sync1, din1, busy1, done1, ovr1};
        if (sel == 2) {o_sclk, o_sync, o_din, o_busy, o_done, o_ovr} = {sclk2, sync2, din2, busy2, done2, ovr2};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_en();
        en0 = en_cur && (sel == 0);
        en1 = en_cur && (sel == 1);
        en2 = en_cur && (sel == 2);
    endtask

    function automatic int ob_at(input int i);
        return (ob_start.size() > i) ? ob_start[i] : -1;
    endfunction

    // One segment: reset, release at sample 0, run n clocks, then score against the model.
    task automatic run_seg(input int s, input int n, input int sig_mode, input logic [15:0] sig_v,
                           input int rst_fall, input int en_drop, input int clr_a, input int clr_b,
                           input string name);
        int cdv, sdv, flen, run, last_start, cur_start, cur_n, fall_total, last_fall;
        int bad_idle, bad_busy, bad_done, bad_period, bad_stable, bad_ovr, n_done, nexp;
        logic [15:0] cur_bits;
        logic prev_sync, prev_sclk, prev_din, in_frame, pulsed, pulse_now, ovr_m, ovr_tick;
        int exp_start[$];
        logic [15:0] exp_data[$];

        sel  = s;
        cdv  = (s == 2) ? 3 : 1;
        sdv  = (s == 0) ? 50 : (s == 1) ? 20 : 100;
        flen = 32 * cdv + 1;
        ob_start.delete(); ob_len.delete(); ob_nbits.delete(); ob_data.delete();
        for (int i = 0; i < MAXN; i++) begin
            rst_pulse[i] = 1'b0;
            ovr_obs[i]   = 1'b0;
        end
        bad_idle = 0; bad_busy = 0; bad_done = 0; bad_period = 0; bad_stable = 0; bad_ovr = 0; n_done = 0;

        @(negedge clk);
        rst_n = 1'b0; clr_ovr = 1'b0; en_cur = 1'b1; drive_en();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            sig = 16'($urandom);
            if ({o_sclk, o_sync, o_din, o_busy, o_done, o_ovr} !== 6'b110000) bad_idle++;
        end

        prev_sync = 1'b1; prev_sclk = 1'b1; prev_din = 1'b0;
        in_frame = 1'b0; pulsed = 1'b0; fall_total = 0;
        cur_start = 0; cur_n = 0; cur_bits = 16'd0; last_fall = -1;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            ovr_obs[c] = o_ovr;
            if (o_busy !== ~o_sync) bad_busy++;
            if (o_done !== (!prev_sync && o_sync)) bad_done++;
            if (o_done === 1'b1) n_done++;
            if (prev_sync && !o_sync) begin
                in_frame = 1'b1; cur_start = c; cur_n = 0; cur_bits = 16'd0; last_fall = -1;
            end else if (in_frame && !prev_sync && !o_sync && !(!prev_sclk && o_sclk) && (o_din !== prev_din)) begin
                bad_stable++;
            end
            if (in_frame && prev_sclk && !o_sclk) begin
                cur_bits = {cur_bits[14:0], o_din};
                cur_n++;
                fall_total++;
                if (last_fall >= 0 && (c - last_fall) != 2 * cdv) bad_period++;
                last_fall = c;
            end
            if (in_frame && !prev_sync && o_sync) begin
                ob_start.push_back(cur_start);
                ob_len.push_back(c - cur_start);
                ob_nbits.push_back(cur_n);
                ob_data.push_back(cur_bits);
                in_frame = 1'b0;
            end
            pulse_now = (rst_fall > 0) && !pulsed && (fall_total == rst_fall);
            if (pulse_now) begin
                pulsed = 1'b1;
                rst_n  = 1'b0;
                #1;
                check({name, ":rst_async_idle"}, 32'({o_sclk, o_sync, o_din, o_busy, o_done}), 32'b11000);
                rst_pulse[c] = 1'b1;
                in_frame = 1'b0;
            end
            prev_sync = o_sync; prev_sclk = o_sclk; prev_din = o_din;

            rst_n   = !pulse_now;
            en_cur  = !(en_drop >= 0 && c >= en_drop);
            drive_en();
            clr_ovr = (c == clr_a) || (c == clr_b);
            if (sig_mode == 0) sig = sig_v;
            else if (sig_mode == 1) sig = (c == 0) ? sig_v : sig + 16'd1;
            else sig = 16'($urandom);
            sig_log[c] = sig; en_log[c] = en_cur; clr_log[c] = clr_ovr; rst_log[c] = rst_n;
        end

        // Model: ticks every SAMPLE_DIV enabled clocks; a tick starts a frame only if the previous one has ended.
        run = 0; last_start = -100000; ovr_m = 1'b0;
        for (int c = 1; c < n; c++) begin
            ovr_tick = 1'b0;
            if (!rst_log[c-1]) begin
                run = 0; last_start = -100000; ovr_m = 1'b0;
            end else begin
                run = en_log[c-1] ? run + 1 : 0;
                if (run > 0 && (run % sdv) == 0) begin
                    if (c > last_start + flen) begin
                        exp_start.push_back(c);
                        exp_data.push_back({4'b0000, sig_log[c-1][15:4]});
                        last_start = c;
                    end else begin
                        ovr_tick = 1'b1;
                    end
                end
                if (ovr_tick) ovr_m = 1'b1;
                else if (clr_log[c-1]) ovr_m = 1'b0;
            end
            if (ovr_obs[c] !== ovr_m) bad_ovr++;
            if (rst_pulse[c]) begin
                if (exp_start.size() > 0 && c < last_start + flen) begin
                    void'(exp_start.pop_back());
                    void'(exp_data.pop_back());
                end
                last_start = -100000; ovr_m = 1'b0;
            end
        end
        while (exp_start.size() > 0 && exp_start[exp_start.size()-1] + flen > n - 1) begin
            void'(exp_start.pop_back());
            void'(exp_data.pop_back());
        end

        check({name, ":idle_in_reset"}, 32'(bad_idle), 0);
        check({name, ":frame_count"}, 32'(ob_start.size()), 32'(exp_start.size()));
        nexp = (ob_start.size() < exp_start.size()) ? ob_start.size() : exp_start.size();
        for (int i = 0; i < nexp; i++) begin
            check($sformatf("%s:start[%0d]", name, i), 32'(ob_start[i]), 32'(exp_start[i]));
            check($sformatf("%s:data[%0d]", name, i), 32'(ob_data[i]), 32'(exp_data[i]));
            check($sformatf("%s:len[%0d]", name, i), 32'(ob_len[i]), 32'(flen));
            check($sformatf("%s:nbits[%0d]", name, i), 32'(ob_nbits[i]), 32'd16);
        end
        check({name, ":done_pulses"}, 32'(n_done), 32'(ob_start.size()));
        check({name, ":done_timing"}, 32'(bad_done), 0);
        check({name, ":busy_vs_sync"}, 32'(bad_busy), 0);
        check({name, ":sclk_period"}, 32'(bad_period), 0);
        check({name, ":din_stable"}, 32'(bad_stable), 0);
        check({name, ":overrun_trace"}, 32'(bad_ovr), 0);
    endtask

    initial begin
        n_tests = 0; n_fail = 0; sel = 0;
        rst_n = 1'b0; clr_ovr = 1'b0; sig = 16'd0; en_cur = 1'b0;
        en0 = 1'b0; en1 = 1'b0; en2 = 1'b0;

        run_seg(0, 400, 2, 16'd0, 0, -1, -1, -1, "reset_release");
        check("reset_release:first_sync_fall", 32'(ob_at(0)), 32'd50);

        run_seg(0, 120, 0, 16'hABCD, 0, -1, -1, -1, "abcd");
        check("abcd:data", (ob_data.size() > 0) ? 32'(ob_data[0]) : 32'hFFFF_FFFF, 32'h0ABC);
        check("abcd:sync_low", (ob_len.size() > 0) ? 32'(ob_len[0]) : 32'hFFFF_FFFF, 32'd33);

        run_seg(0, 1035, 1, 16'($urandom), 0, -1, -1, -1, "ramp");
        check("ramp:twenty_frames", 32'(ob_start.size()), 32'd20);
        check("ramp:spacing", 32'(ob_at(19) - ob_at(0)), 32'd950);

        run_seg(1, 300, 2, 16'd0, 0, -1, 50, 119, "overrun");
        check("overrun:before_collision", 32'(ovr_obs[39]), 0);
        check("overrun:set_on_collision", 32'(ovr_obs[40]), 1);
        check("overrun:cleared", 32'(ovr_obs[51]), 0);
        check("overrun:held_clear", 32'(ovr_obs[79]), 0);
        check("overrun:set_again", 32'(ovr_obs[80]), 1);
        check("overrun:set_beats_clear", 32'(ovr_obs[120]), 1);
        check("overrun:next_frame_start", 32'(ob_at(1)), 32'd60);

        run_seg(2, 250, 0, 16'hFFFF, 0, -1, -1, -1, "clkdiv3");
        check("clkdiv3:data", (ob_data.size() > 0) ? 32'(ob_data[0]) : 32'hFFFF_FFFF, 32'h0FFF);
        check("clkdiv3:frame_len", (ob_len.size() > 0) ? 32'(ob_len[0]) : 32'hFFFF_FFFF, 32'd97);

        run_seg(0, 250, 2, 16'd0, 7, -1, -1, -1, "rst_mid_frame");
        check("rst_mid_frame:restart", 32'(ob_at(0)), 32'd114);

        run_seg(0, 300, 2, 16'd0, 0, 100 + int'($urandom_range(5, 25)), -1, -1, "enable_drop");
        check("enable_drop:frames", 32'(ob_start.size()), 32'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
